// File: rtl/alu_exerciser.sv
// Built-in self-test master for the datapath ALU: drives a fixed opcode sweep with
// latched seed operands and checks each result and Zero flag against a golden model.
module alu_exerciser #(
   parameter int         WIDTH     = 32,
   parameter int         SETTLE    = 1,
   parameter logic [3:0] IDLE_CTRL = 4'd9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] seedA,
   input  logic [WIDTH-1:0] seedB,
   output logic [WIDTH-1:0] entradaA,
   output logic [WIDTH-1:0] entradaB,
   output logic [3:0]       entradaControl,
   input  logic [WIDTH-1:0] ALUresult,
   input  logic             Zero,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       err_count,
   output logic [3:0]       fail_op
);

   // state  | meaning
   // IDLE   | waiting for start; outputs hold last pass summary
   // DRIVE  | present latched seeds and opcode of current index
   // WAIT   | let the ALU settle for SETTLE cycles
   // CHECK  | compare ALU outputs with golden model, advance index
   // FINISH | pulse done, publish pass, park opcode at IDLE_CTRL
   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_FINISH
   } state_t;

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] seed_a_q, seed_a_d;
   logic [WIDTH-1:0] seed_b_q, seed_b_d;
   logic [WIDTH-1:0] ent_a_q, ent_a_d;
   logic [WIDTH-1:0] ent_b_q, ent_b_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [3:0]       err_q, err_d;
   logic [3:0]       fail_op_q, fail_op_d;

   logic [3:0]       cur_op;
   logic [WIDTH-1:0] exp_res;
   logic             exp_zero;
   logic             mismatch;

   function automatic logic [3:0] op_code(input logic [2:0] idx);
      logic [3:0] c;
      case (idx)
         3'd0:    c = 4'd0;
         3'd1:    c = 4'd1;
         3'd2:    c = 4'd2;
         3'd3:    c = 4'd6;
         3'd4:    c = 4'd7;
         default: c = 4'd12;
      endcase
      return c;
   endfunction

   // Golden model works from the latched seeds, not the ALU-facing registers.
   always_comb begin
      cur_op  = op_code(idx_q);
      exp_res = '0;
      case (cur_op)
         4'd0:    exp_res = seed_a_q & seed_b_q;
         4'd1:    exp_res = seed_a_q | seed_b_q;
         4'd2:    exp_res = seed_a_q + seed_b_q;
         4'd6:    exp_res = seed_a_q - seed_b_q;
         4'd7:    exp_res[0] = $signed(seed_a_q) < $signed(seed_b_q);
         default: exp_res = ~(seed_a_q | seed_b_q);
      endcase
      exp_zero = (exp_res == '0);
      mismatch = (ALUresult != exp_res) || (Zero != exp_zero);
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      seed_a_d  = seed_a_q;
      seed_b_d  = seed_b_q;
      ent_a_d   = ent_a_q;
      ent_b_d   = ent_b_q;
      ctrl_d    = ctrl_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      err_d     = err_q;
      fail_op_d = fail_op_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_a_d  = seedA;
               seed_b_d  = seedB;
               err_d     = 4'd0;
               fail_op_d = 4'hF;
               pass_d    = 1'b0;
               busy_d    = 1'b1;
               idx_d     = 3'd0;
               state_d   = S_DRIVE;
            end
         end
         S_DRIVE: begin
            ent_a_d = seed_a_q;
            ent_b_d = seed_b_q;
            ctrl_d  = cur_op;
            cnt_d   = CW'(SETTLE);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != 4'd15) err_d = err_q + 4'd1;
               if (fail_op_q == 4'hF) fail_op_d = cur_op;
            end
            if (idx_q == 3'd5) begin
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_DRIVE;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_q == 4'd0);
            ctrl_d  = IDLE_CTRL;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= 3'd0;
         cnt_q     <= '0;
         seed_a_q  <= '0;
         seed_b_q  <= '0;
         ent_a_q   <= '0;
         ent_b_q   <= '0;
         ctrl_q    <= IDLE_CTRL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= 4'd0;
         fail_op_q <= 4'hF;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         seed_a_q  <= seed_a_d;
         seed_b_q  <= seed_b_d;
         ent_a_q   <= ent_a_d;
         ent_b_q   <= ent_b_d;
         ctrl_q    <= ctrl_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         fail_op_q <= fail_op_d;
      end
   end

   assign entradaA       = ent_a_q;
   assign entradaB       = ent_b_q;
   assign entradaControl = ctrl_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign fail_op        = fail_op_q;

endmodule
